button_event_queue: RTL and testbench



---
 rtl/button_event_queue.sv | 264 ++++++++++++++++++++++++++
 tb/tb_button_event_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// button_event_queue: button levels -> press/release/auto-repeat events, buffered in a show-ahead FIFO.
// Latency: one cycle from a sampled level change to ev_valid (FIFO empty); simultaneous edges lowest index first.
// Backpressure: ev_valid/ev_ready; when full, edges stay pending, due repeats are dropped, overflow is flagged.

module bq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Full looks only at the registered count: a same-cycle pop never frees a slot.
    assign full    = (count == CW'(DEPTH));
    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && pop_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module button_event_queue #(
    parameter int              NBTN         = 11,
    parameter int              DEPTH        = 8,
    parameter logic [NBTN-1:0] REPEAT_MASK  = NBTN'(11'h00F),
    parameter int              REPEAT_DELAY = 6000000,
    parameter int              REPEAT_RATE  = 1200000
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic [NBTN-1:0] buttons,
    input  logic            ev_ready,
    input  logic            clr_overflow,
    output logic            ev_valid,
    output logic [3:0]      ev_idx,
    output logic            ev_press,
    output logic            ev_repeat,
    output logic            overflow
);
    typedef struct packed {
        logic       rep;
        logic       press;
        logic [3:0] idx;
    } ev_t;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX);

    logic [NBTN-1:0] prev;
    logic [NBTN-1:0] pending;
    logic [NBTN-1:0] sel_oh;
    logic [3:0]      sel;
    logic            sel_level;
    logic            sel_mask;
    logic            any_pend;

    logic            fifo_full;
    logic            push_vld;
    ev_t             push_dat;
    ev_t             head_dat;

    logic            edge_push;
    logic            rep_want;
    logic            rep_push;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      tidx;
    logic [RCW-1:0]  rcnt;
    logic            rdue;
    logic            press_trk;
    logic            rel_trk;
    logic            expire;
    logic            ld_delay;
    logic            ld_rate;
    logic            dec_cnt;
    logic            rdue_set;
    logic            rdue_clr;

    assign pending  = buttons ^ prev;
    assign any_pend = |pending;

    // Lowest pending index wins; descending scan lets the lowest hit overwrite.
    always_comb begin
        sel       = '0;
        sel_level = 1'b0;
        sel_mask  = 1'b0;
        sel_oh    = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel       = 4'(i);
                sel_level = buttons[i];
                sel_mask  = REPEAT_MASK[i];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign edge_push = any_pend && !fifo_full;
    assign rep_want  = rdue && !any_pend;
    assign rep_push  = rep_want && !fifo_full;
    assign push_vld  = edge_push || rep_push;

    always_comb begin
        push_dat = '0;
        if (any_pend) begin
            push_dat.rep   = 1'b0;
            push_dat.press = sel_level;
            push_dat.idx   = sel;
        end else begin
            push_dat.rep   = 1'b1;
            push_dat.press = 1'b1;
            push_dat.idx   = tidx;
        end
    end

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            prev <= '0;
        end else if (edge_push) begin
            prev <= prev ^ sel_oh;
        end
    end

    // Repeat tracker events, all qualified by an edge actually entering the FIFO.
    assign press_trk = edge_push && sel_level && sel_mask;
    assign rel_trk   = edge_push && !sel_level && (sel == tidx) && (state != S_IDLE);
    assign expire    = (state != S_IDLE) && (rcnt == '0);

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (press_trk) begin
                    state_nxt = S_DELAY;
                end
            end
            default: begin
                if (press_trk) begin
                    state_nxt = S_DELAY;
                end else if (rel_trk) begin
                    state_nxt = S_IDLE;
                end else if (expire) begin
                    state_nxt = S_REPEAT;
                end
            end
        endcase
    end

    always_comb begin
        ld_delay = press_trk;
        ld_rate  = 1'b0;
        dec_cnt  = 1'b0;
        rdue_set = 1'b0;
        rdue_clr = press_trk || rel_trk;
        if (state != S_IDLE && !press_trk && !rel_trk) begin
            ld_rate  = expire;
            rdue_set = expire;
            dec_cnt  = !expire;
        end
    end

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            tidx <= '0;
            rcnt <= '0;
            rdue <= 1'b0;
        end else begin
            if (press_trk) begin
                tidx <= sel;
            end
            if (ld_delay) begin
                rcnt <= RCW'(REPEAT_DELAY - 1);
            end else if (ld_rate) begin
                rcnt <= RCW'(REPEAT_RATE - 1);
            end else if (dec_cnt) begin
                rcnt <= rcnt - RCW'(1);
            end
            // A fresh expiry outranks consuming the previous one in the same cycle.
            if (rdue_set) begin
                rdue <= 1'b1;
            end else if (rdue_clr || rep_want) begin
                rdue <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            overflow <= 1'b0;
        end else if ((any_pend || rep_want) && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    bq_fifo #(
        .W     ($bits(ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (resetq),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (ev_ready),
        .pop_vld  (ev_valid),
        .pop_dat  (head_dat),
        .full     (fifo_full)
    );

    assign ev_idx    = head_dat.idx;
    assign ev_press  = head_dat.press;
    assign ev_repeat = head_dat.rep;
endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue with DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=4.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_button_event_queue;
    localparam int NBTN = 11;

    logic            clk = 1'b0;
    logic            resetq = 1'b1;
    logic [NBTN-1:0] buttons = '0;
    logic            ev_ready = 1'b0;
    logic            clr_overflow = 1'b0;
    logic            ev_valid;
    logic [3:0]      ev_idx;
    logic            ev_press;
    logic            ev_repeat;
    logic            overflow;

    button_event_queue #(
        .NBTN         (NBTN),
        .DEPTH        (4),
        .REPEAT_MASK  (11'h00F),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (4)
    ) dut (
        .clk          (clk),
        .resetq       (resetq),
        .buttons      (buttons),
        .ev_ready     (ev_ready),
        .clr_overflow (clr_overflow),
        .ev_valid     (ev_valid),
        .ev_idx       (ev_idx),
        .ev_press     (ev_press),
        .ev_repeat    (ev_repeat),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] sb[$];
    int         rep_off[$];
    int         last_press_cyc = 0;
    logic [5:0] mon_got;
    logic [5:0] mon_exp;

    typedef struct {
        logic [NBTN-1:0] btn;
        int              n;
        logic [5:0]      e [3];
    } vec_t;

    vec_t vecs [8];

    function automatic logic [5:0] ev(input int idx, input bit press, input bit rep);
        return {rep, press, 4'(idx)};
    endfunction

    function automatic vec_t mkv(input logic [NBTN-1:0] btn, input int n,
                                 input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2);
        vec_t v;
        v.btn  = btn;
        v.n    = n;
        v.e[0] = e0;
        v.e[1] = e1;
        v.e[2] = e2;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_outstanding"}, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted head event is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!resetq && ev_valid && ev_ready) begin
            mon_got = {ev_repeat, ev_press, ev_idx};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got rep=%0d press=%0d idx=%0d, expected none",
                         ev_repeat, ev_press, ev_idx);
            end else begin
                mon_exp = sb.pop_front();
                checks++;
                if (mon_got != mon_exp) begin
                    errors++;
                    $display("FAIL event: got rep=%0d press=%0d idx=%0d, expected rep=%0d press=%0d idx=%0d",
                             mon_got[5], mon_got[4], mon_got[3:0], mon_exp[5], mon_exp[4], mon_exp[3:0]);
                end
            end
            if (ev_repeat) rep_off.push_back(cyc - last_press_cyc);
            else if (ev_press) last_press_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c [5] = '{11, 15, 19, 23, 27};
        int exp_d [4] = '{11, 15, 19, 23};

        vecs[0] = mkv(11'h101, 2, ev(0, 1, 0), ev(8, 1, 0), 6'd0);
        vecs[1] = mkv(11'h000, 2, ev(0, 0, 0), ev(8, 0, 0), 6'd0);
        vecs[2] = mkv(11'h030, 2, ev(4, 1, 0), ev(5, 1, 0), 6'd0);
        vecs[3] = mkv(11'h460, 3, ev(4, 0, 0), ev(6, 1, 0), ev(10, 1, 0));
        vecs[4] = mkv(11'h440, 1, ev(5, 0, 0), 6'd0, 6'd0);
        vecs[5] = mkv(11'h000, 2, ev(6, 0, 0), ev(10, 0, 0), 6'd0);
        vecs[6] = mkv(11'h600, 2, ev(9, 1, 0), ev(10, 1, 0), 6'd0);
        vecs[7] = mkv(11'h000, 2, ev(9, 0, 0), ev(10, 0, 0), 6'd0);

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_idx", int'(ev_idx), 0);
        chk("rst_ev_press", int'(ev_press), 0);
        chk("rst_ev_repeat", int'(ev_repeat), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        resetq = 1'b0;
        tick(2);

        // Single press: one-cycle latency, stable head while not ready
        buttons = 11'h200;
        sb.push_back(ev(9, 1, 0));
        @(negedge clk);
        chk("latency_not_before_edge", int'(ev_valid), 0);
        @(negedge clk);
        chk("latency_valid", int'(ev_valid), 1);
        chk("latency_idx", int'(ev_idx), 9);
        chk("latency_press", int'(ev_press), 1);
        chk("latency_repeat", int'(ev_repeat), 0);
        @(negedge clk);
        chk("stable_idx", int'(ev_idx), 9);
        chk("stable_valid", int'(ev_valid), 1);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        wait_drain("press9", 20);
        buttons = 11'h000;
        sb.push_back(ev(9, 0, 0));
        wait_drain("release9", 20);

        // Table of level patterns, each held below the repeat delay
        for (int r = 0; r < 8; r++) begin
            buttons = vecs[r].btn;
            for (int k = 0; k < vecs[r].n; k++) sb.push_back(vecs[r].e[k]);
            tick(6);
            wait_drain($sformatf("row%0d", r), 20);
        end

        // Auto-repeat on bit 2 held for 30 cycles
        rep_off.delete();
        buttons = 11'h004;
        sb.push_back(ev(2, 1, 0));
        for (int k = 0; k < 5; k++) sb.push_back(ev(2, 1, 1));
        tick(30);
        buttons = 11'h000;
        sb.push_back(ev(2, 0, 0));
        wait_drain("repeat", 60);
        tick(20);
        chk("repeat_count", rep_off.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < rep_off.size()) chk($sformatf("repeat_offset%0d", k), rep_off[k], exp_c[k]);
            else chk($sformatf("repeat_offset%0d", k), -1, exp_c[k]);
        end

        // Retarget from bit 0 to bit 1, then release bit 0
        rep_off.delete();
        buttons = 11'h001;
        sb.push_back(ev(0, 1, 0));
        tick(5);
        buttons = 11'h003;
        sb.push_back(ev(1, 1, 0));
        sb.push_back(ev(1, 1, 1));
        tick(14);
        buttons = 11'h002;
        sb.push_back(ev(0, 0, 0));
        for (int k = 0; k < 3; k++) sb.push_back(ev(1, 1, 1));
        tick(10);
        buttons = 11'h000;
        sb.push_back(ev(1, 0, 0));
        wait_drain("retarget", 60);
        tick(20);
        chk("retarget_count", rep_off.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < rep_off.size()) chk($sformatf("retarget_offset%0d", k), rep_off[k], exp_d[k]);
            else chk($sformatf("retarget_offset%0d", k), -1, exp_d[k]);
        end

        // Overflow: five presses into a four-entry FIFO with the consumer stalled
        ev_ready = 1'b0;
        for (int b = 4; b <= 8; b++) begin
            buttons[b] = 1'b1;
            sb.push_back(ev(b, 1, 0));
            tick(2);
        end
        tick(2);
        @(negedge clk);
        chk("full_valid", int'(ev_valid), 1);
        chk("full_head_idx", int'(ev_idx), 4);
        chk("full_overflow", int'(overflow), 1);
        @(posedge clk); #1;
        buttons[9] = 1'b1;
        tick(1);
        buttons[9] = 1'b0;
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        @(negedge clk);
        chk("set_beats_clear", int'(overflow), 1);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        clr_overflow = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        clr_overflow = 1'b0;
        @(negedge clk);
        chk("pop_next_head", int'(ev_idx), 5);
        chk("pop_no_room_overflow", int'(overflow), 1);
        @(posedge clk); #1;
        tick(1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        @(negedge clk);
        chk("clr_overflow", int'(overflow), 0);
        chk("refilled_valid", int'(ev_valid), 1);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        buttons = 11'h000;
        for (int b = 4; b <= 8; b++) sb.push_back(ev(b, 0, 0));
        wait_drain("overflow_drain", 60);
        tick(10);

        // Reset with entries queued and a repeat being dropped
        ev_ready = 1'b0;
        buttons = 11'h031;
        tick(20);
        @(negedge clk);
        chk("pre_reset_valid", int'(ev_valid), 1);
        chk("dropped_repeat_overflow", int'(overflow), 1);
        @(posedge clk); #1;
        resetq = 1'b1;
        tick(2);
        @(negedge clk);
        chk("midrst_valid", int'(ev_valid), 0);
        chk("midrst_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        resetq = 1'b0;
        ev_ready = 1'b1;
        sb.push_back(ev(0, 1, 0));
        sb.push_back(ev(4, 1, 0));
        sb.push_back(ev(5, 1, 0));
        tick(5);
        buttons = 11'h000;
        sb.push_back(ev(0, 0, 0));
        sb.push_back(ev(4, 0, 0));
        sb.push_back(ev(5, 0, 0));
        wait_drain("post_reset", 40);
        tick(15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
